// File: rtl/segment_sequencer.sv
// Fetches 3D segment endpoints from word-addressed point memory and presents each segment once per view.
// Optional build macro SEGSEQ_SKIP_DEGENERATE_EN: drop zero-length segments and count them on skipped_o.
module segment_sequencer #(
  parameter int COORD_W         = 16,
  parameter int ADDR_W          = 20,
  parameter int ANG_W           = 16,
  parameter int N_VIEWS         = 2,
  parameter int HALF_VIEW_ANGLE = 520,
  parameter int VIEW_W          = (N_VIEWS > 1) ? $clog2(N_VIEWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   strip_i,
  input  logic                   views_en_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [ADDR_W-1:0]      count_i,
  input  logic [ANG_W-1:0]       alpha_i,
  input  logic [ANG_W-1:0]       beta_i,
  input  logic [ANG_W-1:0]       gamma_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_rd_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic                   mem_busy_i,
  input  logic [COORD_W-1:0]     mem_data_i,
  output logic                   seg_valid_o,
  input  logic                   seg_ready_i,
  output logic [3*COORD_W-1:0]   seg_p1_o,
  output logic [3*COORD_W-1:0]   seg_p2_o,
  output logic [ANG_W-1:0]       seg_alpha_o,
  output logic [ANG_W-1:0]       seg_beta_o,
  output logic [ANG_W-1:0]       seg_gamma_o,
  output logic [VIEW_W-1:0]      seg_view_o
`ifdef SEGSEQ_SKIP_DEGENERATE_EN
  ,
  output logic [ADDR_W-1:0]      skipped_o
`endif
);

  localparam logic [ANG_W-1:0]  GAMMA_FIRST_OFS = ANG_W'((N_VIEWS - 1) * HALF_VIEW_ANGLE);
  localparam logic [ANG_W-1:0]  GAMMA_STEP      = ANG_W'(2 * HALF_VIEW_ANGLE);
  localparam logic [VIEW_W-1:0] LAST_VIEW       = VIEW_W'(N_VIEWS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t              state;
  logic                stripL;
  logic                viewsEnL;
  logic [ADDR_W-1:0]   segLeft;
  logic [2:0]          wordIdx;
  logic [ANG_W-1:0]    gammaL;
  logic [ADDR_W-1:0]   startTotal;
  logic                lastWord;
  logic                lastView;
  logic                lastSeg;
  logic                skipSeg;

  // Strip mode shares endpoints, so N points give N-1 segments.
  always_comb begin
    startTotal = count_i;
    if (strip_i) begin
      startTotal = (count_i < ADDR_W'(2)) ? '0 : count_i - ADDR_W'(1);
    end
  end

  assign lastWord = (wordIdx == 3'd5);
  assign lastView = !viewsEnL || (seg_view_o == LAST_VIEW);
  assign lastSeg  = (segLeft == ADDR_W'(1));

`ifdef SEGSEQ_SKIP_DEGENERATE_EN
  // Z2 is still on the bus when the last word lands, so compare against it directly.
  assign skipSeg = (state == FETCH) && !mem_busy_i && lastWord &&
                   (seg_p1_o == {seg_p2_o[3*COORD_W-1:COORD_W], mem_data_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skipped_o <= '0;
    end else if (state == IDLE && start_i) begin
      skipped_o <= '0;
    end else if (skipSeg) begin
      skipped_o <= skipped_o + ADDR_W'(1);
    end
  end
`else
  assign skipSeg = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stripL      <= 1'b0;
      viewsEnL    <= 1'b0;
      segLeft     <= '0;
      wordIdx     <= '0;
      gammaL      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_rd_o    <= 1'b0;
      mem_addr_o  <= '0;
      seg_valid_o <= 1'b0;
      seg_p1_o    <= '0;
      seg_p2_o    <= '0;
      seg_alpha_o <= '0;
      seg_beta_o  <= '0;
      seg_gamma_o <= '0;
      seg_view_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            stripL      <= strip_i;
            viewsEnL    <= views_en_i;
            mem_addr_o  <= base_addr_i;
            segLeft     <= startTotal;
            wordIdx     <= '0;
            gammaL      <= gamma_i;
            seg_alpha_o <= alpha_i;
            seg_beta_o  <= beta_i;
            seg_view_o  <= '0;
            busy_o      <= 1'b1;
            if (startTotal == '0) begin
              state <= DONE;
            end else begin
              state    <= FETCH;
              mem_rd_o <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (!mem_busy_i) begin
            case (wordIdx)
              3'd0:    seg_p1_o[3*COORD_W-1 -: COORD_W] <= mem_data_i;
              3'd1:    seg_p1_o[2*COORD_W-1 -: COORD_W] <= mem_data_i;
              3'd2:    seg_p1_o[COORD_W-1:0]            <= mem_data_i;
              3'd3:    seg_p2_o[3*COORD_W-1 -: COORD_W] <= mem_data_i;
              3'd4:    seg_p2_o[2*COORD_W-1 -: COORD_W] <= mem_data_i;
              default: seg_p2_o[COORD_W-1:0]            <= mem_data_i;
            endcase
            mem_addr_o <= mem_addr_o + ADDR_W'(1);
            wordIdx    <= wordIdx + 3'd1;
            if (lastWord) begin
              if (skipSeg) begin
                segLeft <= segLeft - ADDR_W'(1);
                if (lastSeg) begin
                  state    <= DONE;
                  mem_rd_o <= 1'b0;
                end else begin
                  wordIdx <= stripL ? 3'd3 : 3'd0;
                  if (stripL) begin
                    seg_p1_o <= {seg_p2_o[3*COORD_W-1:COORD_W], mem_data_i};
                  end
                end
              end else begin
                state       <= PRESENT;
                mem_rd_o    <= 1'b0;
                seg_valid_o <= 1'b1;
                seg_view_o  <= '0;
                seg_gamma_o <= viewsEnL ? gammaL - GAMMA_FIRST_OFS : gammaL;
              end
            end
          end
        end

        PRESENT: begin
          if (seg_ready_i) begin
            if (!lastView) begin
              seg_view_o  <= seg_view_o + VIEW_W'(1);
              seg_gamma_o <= seg_gamma_o + GAMMA_STEP;
            end else begin
              seg_valid_o <= 1'b0;
              segLeft     <= segLeft - ADDR_W'(1);
              if (lastSeg) begin
                state <= DONE;
              end else begin
                state    <= FETCH;
                mem_rd_o <= 1'b1;
                wordIdx  <= stripL ? 3'd3 : 3'd0;
                if (stripL) begin
                  seg_p1_o <= seg_p2_o;
                end
              end
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_sequencer.sv
// Randomized self-checking bench for segment_sequencer against a segment/view list model.
module tb_segment_sequencer;

  localparam int COORD_W = 16;
  localparam int ADDR_W  = 20;
  localparam int ANG_W   = 16;
  localparam int N_VIEWS = 2;
  localparam int HALF    = 520;
  localparam int VIEW_W  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start_i;
  logic                 strip_i;
  logic                 views_en_i;
  logic [ADDR_W-1:0]    base_addr_i;
  logic [ADDR_W-1:0]    count_i;
  logic [ANG_W-1:0]     alpha_i;
  logic [ANG_W-1:0]     beta_i;
  logic [ANG_W-1:0]     gamma_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 mem_rd_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_busy_i;
  logic [COORD_W-1:0]   mem_data_i;
  logic                 seg_valid_o;
  logic                 seg_ready_i;
  logic [3*COORD_W-1:0] seg_p1_o;
  logic [3*COORD_W-1:0] seg_p2_o;
  logic [ANG_W-1:0]     seg_alpha_o;
  logic [ANG_W-1:0]     seg_beta_o;
  logic [ANG_W-1:0]     seg_gamma_o;
  logic [VIEW_W-1:0]    seg_view_o;
`ifdef SEGSEQ_SKIP_DEGENERATE_EN
  logic [ADDR_W-1:0]    skipped_o;
`endif

  segment_sequencer #(
    .COORD_W(COORD_W), .ADDR_W(ADDR_W), .ANG_W(ANG_W),
    .N_VIEWS(N_VIEWS), .HALF_VIEW_ANGLE(HALF), .VIEW_W(VIEW_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .strip_i(strip_i),
    .views_en_i(views_en_i), .base_addr_i(base_addr_i), .count_i(count_i),
    .alpha_i(alpha_i), .beta_i(beta_i), .gamma_i(gamma_i),
    .busy_o(busy_o), .done_o(done_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_busy_i(mem_busy_i), .mem_data_i(mem_data_i),
    .seg_valid_o(seg_valid_o), .seg_ready_i(seg_ready_i),
    .seg_p1_o(seg_p1_o), .seg_p2_o(seg_p2_o),
    .seg_alpha_o(seg_alpha_o), .seg_beta_o(seg_beta_o), .seg_gamma_o(seg_gamma_o),
    .seg_view_o(seg_view_o)
`ifdef SEGSEQ_SKIP_DEGENERATE_EN
    , .skipped_o(skipped_o)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] memArr [0:1023];
  assign mem_data_i = memArr[mem_addr_o[9:0]];

  typedef struct {
    logic [47:0] p1;
    logic [47:0] p2;
    logic [15:0] alpha;
    logic [15:0] beta;
    logic [15:0] gamma;
    int          view;
  } seg_t;

  seg_t        expSeg[$];
  logic [19:0] expAddr[$];
  int          expSkipped;
  int          assertCount = 0;
  int          failCount   = 0;
  int          busyMode    = 0;
  int          readyMode   = 0;
  int          stallLeft   = 0;
  seg_t        monSeg;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [19:0] base, input int ofs);
    logic [19:0] a;
    a = 20'(int'(base) + ofs);
    return memArr[a[9:0]];
  endfunction

  // Reference: flat list of expected read addresses and (segment, view) payloads.
  function automatic void buildExpect(input bit strip, input bit viewsEn, input logic [19:0] base,
                                      input int cnt, input logic [15:0] gamma,
                                      input logic [15:0] alpha, input logic [15:0] beta);
    int   total;
    int   nWords;
    int   o1;
    seg_t s;
    expAddr.delete();
    expSeg.delete();
    expSkipped = 0;
    total  = strip ? ((cnt < 2) ? 0 : cnt - 1) : cnt;
    nWords = (total == 0) ? 0 : (strip ? 3 * cnt : 6 * cnt);
    for (int i = 0; i < nWords; i++) expAddr.push_back(20'(int'(base) + i));
    for (int k = 0; k < total; k++) begin
      o1 = strip ? 3 * k : 6 * k;
      s.p1 = {memWord(base, o1), memWord(base, o1 + 1), memWord(base, o1 + 2)};
      s.p2 = {memWord(base, o1 + 3), memWord(base, o1 + 4), memWord(base, o1 + 5)};
`ifdef SEGSEQ_SKIP_DEGENERATE_EN
      if (s.p1 == s.p2) begin
        expSkipped++;
        continue;
      end
`endif
      s.alpha = alpha;
      s.beta  = beta;
      for (int v = 0; v < (viewsEn ? N_VIEWS : 1); v++) begin
        s.view  = v;
        s.gamma = viewsEn ? 16'(int'(gamma) + (2 * v - (N_VIEWS - 1)) * HALF) : gamma;
        expSeg.push_back(s);
      end
    end
  endfunction

  // Memory stall and downstream backpressure patterns.
  initial begin
    mem_busy_i  = 1'b0;
    seg_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (busyMode)
        0:       mem_busy_i = 1'b0;
        1:       mem_busy_i = ~mem_busy_i;
        default: mem_busy_i = 1'($urandom_range(0, 1));
      endcase
      case (readyMode)
        0: seg_ready_i = 1'b1;
        1: seg_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (seg_valid_o && stallLeft > 0) begin
            seg_ready_i = 1'b0;
            stallLeft--;
          end else begin
            seg_ready_i = 1'b1;
          end
        end
        default: seg_ready_i = 1'b0;
      endcase
    end
  end

  // Reads must follow the expected address order; a held payload must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_o && !mem_busy_i) begin
        checkEq("rd_expected", 64'(expAddr.size() > 0), 1);
        if (expAddr.size() > 0) checkEq("rd_addr", mem_addr_o, expAddr.pop_front());
      end
      if (seg_valid_o) begin
        checkEq("seg_expected", 64'(expSeg.size() > 0), 1);
        if (expSeg.size() > 0) begin
          monSeg = expSeg[0];
          checkEq("seg_p1", seg_p1_o, monSeg.p1);
          checkEq("seg_p2", seg_p2_o, monSeg.p2);
          checkEq("seg_alpha", seg_alpha_o, monSeg.alpha);
          checkEq("seg_beta", seg_beta_o, monSeg.beta);
          checkEq("seg_gamma", seg_gamma_o, monSeg.gamma);
          checkEq("seg_view", seg_view_o, monSeg.view);
          if (seg_ready_i) void'(expSeg.pop_front());
        end
      end
    end
  end

  task automatic checkIdleOutputs();
    checkEq("rst_busy", busy_o, 0);
    checkEq("rst_done", done_o, 0);
    checkEq("rst_mem_rd", mem_rd_o, 0);
    checkEq("rst_mem_addr", mem_addr_o, 0);
    checkEq("rst_valid", seg_valid_o, 0);
    checkEq("rst_p1", seg_p1_o, 0);
    checkEq("rst_p2", seg_p2_o, 0);
    checkEq("rst_alpha", seg_alpha_o, 0);
    checkEq("rst_gamma", seg_gamma_o, 0);
    checkEq("rst_view", seg_view_o, 0);
  endtask

  task automatic startPass(input bit strip, input bit viewsEn, input logic [19:0] base, input int cnt,
                           input logic [15:0] gamma, input logic [15:0] alpha, input logic [15:0] beta);
    buildExpect(strip, viewsEn, base, cnt, gamma, alpha, beta);
    stallLeft = 20;
    @(posedge clk);
    #1;
    strip_i     = strip;
    views_en_i  = viewsEn;
    base_addr_i = base;
    count_i     = 20'(cnt);
    gamma_i     = gamma;
    alpha_i     = alpha;
    beta_i      = beta;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i     = 1'b0;
    // Scramble settings: the pass must run on the latched copies.
    strip_i     = 1'($urandom_range(0, 1));
    views_en_i  = 1'($urandom_range(0, 1));
    base_addr_i = 20'($urandom);
    count_i     = 20'($urandom_range(0, 9));
    gamma_i     = 16'($urandom);
    alpha_i     = 16'($urandom);
    beta_i      = 16'($urandom);
  endtask

  task automatic waitDone(input int expLatency, input bit injectStart);
    int cyc;
    bit seen;
    seen = 1'b0;
    for (cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (injectStart && cyc == 8) begin
        base_addr_i = 20'($urandom);
        count_i     = 20'd7;
        start_i     = 1'b1;
      end
      if (injectStart && cyc == 9) start_i = 1'b0;
    end
    checkEq("done_seen", seen, 1);
    if (expLatency > 0) checkEq("done_latency", cyc, expLatency);
    checkEq("addr_left", expAddr.size(), 0);
    checkEq("seg_left", expSeg.size(), 0);
`ifdef SEGSEQ_SKIP_DEGENERATE_EN
    checkEq("skipped", skipped_o, expSkipped);
`endif
    checkEq("busy_at_done", busy_o, 0);
    @(negedge clk);
    checkEq("done_width", done_o, 0);
    checkEq("idle_after_done", busy_o, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    strip_i     = 1'b0;
    views_en_i  = 1'b0;
    base_addr_i = '0;
    count_i     = '0;
    alpha_i     = '0;
    beta_i      = '0;
    gamma_i     = '0;
    for (int i = 0; i < 1024; i++) memArr[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    checkIdleOutputs();
`ifdef SEGSEQ_SKIP_DEGENERATE_EN
    checkEq("rst_skipped", skipped_o, 0);
`endif
    rst_n = 1'b1;

    // Single list segment, two views, no stalls: 1 latch + 6 reads + 2 views + done.
    for (int i = 0; i < 6; i++) memArr[10'h100 + i] = 16'(i + 1);
    startPass(1'b0, 1'b1, 20'h00100, 1, 16'h0000, 16'h1234, 16'h5678);
    waitDone(10, 1'b0);
    $display("pass list_basic done, %0d failures so far", failCount);

    // Polyline strip of three points, single view.
    memArr[10'h200] = 0;  memArr[10'h201] = 0;  memArr[10'h202] = 0;
    memArr[10'h203] = 10; memArr[10'h204] = 0;  memArr[10'h205] = 0;
    memArr[10'h206] = 10; memArr[10'h207] = 10; memArr[10'h208] = 0;
    startPass(1'b1, 1'b0, 20'h00200, 3, 16'h0400, 16'h0011, 16'h0022);
    waitDone(0, 1'b0);
    $display("pass strip_basic done, %0d failures so far", failCount);

    // 20-cycle downstream stall and a toggling memory stall.
    busyMode  = 1;
    readyMode = 2;
    startPass(1'b0, 1'b1, 20'h00040, 2, 16'($urandom), 16'($urandom), 16'($urandom));
    waitDone(0, 1'b0);
    busyMode  = 0;
    readyMode = 0;
    $display("pass backpressure done, %0d failures so far", failCount);

    // Empty passes finish two cycles after start without touching memory.
    startPass(1'b0, 1'b1, 20'h00300, 0, 16'h0, 16'h0, 16'h0);
    waitDone(2, 1'b0);
    startPass(1'b1, 1'b1, 20'h00300, 1, 16'h0, 16'h0, 16'h0);
    waitDone(2, 1'b0);
    startPass(1'b1, 1'b0, 20'h00300, 0, 16'h0, 16'h0, 16'h0);
    waitDone(2, 1'b0);
    $display("pass empty_passes done, %0d failures so far", failCount);

    // A start pulse in the middle of a pass must not disturb it.
    busyMode  = 2;
    readyMode = 1;
    startPass(1'b0, 1'b1, 20'h00080, 3, 16'($urandom), 16'($urandom), 16'($urandom));
    waitDone(0, 1'b1);
    busyMode  = 0;
    readyMode = 0;
    $display("pass mid_start done, %0d failures so far", failCount);

    // Gamma wraps: view 1 of 0x7FF0 is 0x81F8.
    startPass(1'b0, 1'b1, 20'h00140, 1, 16'h7FF0, 16'h0, 16'h0);
    waitDone(0, 1'b0);
    $display("pass gamma_wrap done, %0d failures so far", failCount);

    // First segment degenerate, second normal.
    for (int i = 0; i < 6; i++) memArr[10'h180 + i] = 16'h0007;
    startPass(1'b0, 1'b1, 20'h00180, 2, 16'h0100, 16'h0, 16'h0);
    waitDone(0, 1'b0);
    $display("pass degenerate done, %0d failures so far", failCount);

    // Address wrap across the top of the address space.
    startPass(1'b1, 1'b1, 20'hFFFFB, 4, 16'($urandom), 16'($urandom), 16'($urandom));
    waitDone(0, 1'b0);
    $display("pass addr_wrap done, %0d failures so far", failCount);

    // Reset while presenting abandons the pass silently.
    readyMode = 3;
    startPass(1'b0, 1'b1, 20'h00020, 2, 16'h1111, 16'h2222, 16'h3333);
    for (int c = 0; c < 200 && !seg_valid_o; c++) @(negedge clk);
    checkEq("present_reached", seg_valid_o, 1);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs();
    expSeg.delete();
    expAddr.delete();
    readyMode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkEq("no_done_after_rst", done_o, 0);
    end
    $display("pass reset_in_present done, %0d failures so far", failCount);

    for (int t = 0; t < 24; t++) begin
      busyMode  = $urandom_range(0, 2);
      readyMode = $urandom_range(0, 2);
      startPass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom),
                $urandom_range(0, 5), 16'($urandom), 16'($urandom), 16'($urandom));
      waitDone(0, 1'b0);
      $display("pass random_%0d done, %0d failures so far", t, failCount);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
